if_fetch: RTL

Instruction-fetch stage feeding the IF/ID pipeline register. Owns the fetch PC, issues one-at-a-time requests to instruction memory over a req/ack handshake, and presents fetched instructions to IF/ID as a pc/inst/valid triple. It honours downstream stall through a one-entry skid buffer, and it honours flush/redirect by discarding all unconsumed instructions.

---
 rtl/if_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, talks req/ack to imem,
// and presents pc/inst/valid to IF/ID with a one-entry skid buffer.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  logic out_free;
  logic busy;

  assign out_free = !out_valid_q || !stall_i;
  assign busy     = (state_q == FETCH) || (state_q == FLUSH);

  assign imem_req_o  = busy;
  assign imem_addr_o = fetch_pc_q;
  assign if_valid_o  = out_valid_q;
  assign if_pc_o     = out_pc_q;
  assign if_inst_o   = out_inst_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    out_valid_d  = out_valid_q && stall_i;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (out_free) begin
            out_valid_d = 1'b1;
            out_pc_d    = fetch_pc_q;
            out_inst_d  = imem_rdata_i;
          end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = fetch_pc_q;
            skid_inst_d  = imem_rdata_i;
            state_d      = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!stall_i) begin
          out_valid_d  = skid_valid_q;
          out_pc_d     = skid_pc_q;
          out_inst_d   = skid_inst_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
      default: begin
        if (imem_ack_i) begin
          fetch_pc_d = pending_pc_q;
          state_d    = FETCH;
        end
      end
    endcase

    // A flush must not drop an outstanding request: park the target instead.
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      if (busy && !imem_ack_i) begin
        pending_pc_d = new_pc_i;
        state_d      = FLUSH;
      end else begin
        fetch_pc_d = new_pc_i;
        state_d    = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_pc_q     <= 32'h0;
      out_inst_q   <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_inst_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

endmodule
